// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1-style frame recovery with a mid-bit start check,
// centre-of-bit data sampling, and a one-cycle done strobe carrying word and frame error.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int SB_TICK   = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic [1:0]           o_state
);

    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic                 rx_meta, rx;

    // Idle-high line, so both synchronizer stages come out of reset at 1.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx      <= rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        stop_d  = stop_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            // Start detection runs every clock, not every tick, so back-to-back frames lose nothing.
            IDLE: begin
                if (!rx) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == S_W'(7)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = rx ? IDLE : DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d = '0;
                        b_d = {rx, b_q[DATA_BITS-1:1]};
                        if (n_q == N_W'(DATA_BITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_q == S_W'(7)) begin
                        stop_d = rx;
                    end
                    // A low stop sample still delivers the word, only flagged as a frame error.
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        s_d     = '0;
                        data_d  = b_q;
                        err_d   = ~stop_q;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // o_rx_done is a bare strobe: no back-pressure, o_data/o_frame_err are valid in that cycle.
    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = err_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8-bit/1-stop instance and a 7-bit/2-stop instance
// share the clock, tick and reset; each has its own serial line.
module tb_uart_rx;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STOP = 2'd3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       rx8   = 1'b1;
    logic       rx7   = 1'b1;
    logic [7:0] data8;
    logic       done8, err8;
    logic [1:0] st8;
    logic [6:0] data7;
    logic       done7, err7;
    logic [1:0] st7;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] exp8_q[$], obs8_q[$], exp7_q[$], obs7_q[$];
    int          tk8_q[$], lat8_q[$], tk7_q[$], lat7_q[$];
    int          st_cnt8 = 0, last8 = 0, st_cnt7 = 0, last7 = 0;

    uart_rx dut8 (
        .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx8),
        .o_data(data8), .o_rx_done(done8), .o_frame_err(err8), .o_state(st8)
    );

    uart_rx #(.DATA_BITS(7), .SB_TICK(32)) dut7 (
        .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx7),
        .o_data(data7), .o_rx_done(done7), .o_frame_err(err7), .o_state(st7)
    );

    // clock / tick
    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph   = (ph + 1) % 4;
            tick = (ph == 0);
        end
    end

    // monitor: strobes, STOP tick count and strobe latency after the final STOP tick
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (done8) begin
                obs8_q.push_back({23'd0, err8, data8});
                tk8_q.push_back(st_cnt8);
                lat8_q.push_back(cyc - last8);
            end
            if (st8 == ST_STOP) begin
                if (tick) begin
                    st_cnt8++;
                    last8 = cyc;
                end
            end else begin
                st_cnt8 = 0;
            end
            if (done7) begin
                obs7_q.push_back({23'd0, err7, 1'b0, data7});
                tk7_q.push_back(st_cnt7);
                lat7_q.push_back(cyc - last7);
            end
            if (st7 == ST_STOP) begin
                if (tick) begin
                    st_cnt7++;
                    last7 = cyc;
                end
            end else begin
                st_cnt7 = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx8 = v;
        else          rx7 = v;
    endtask

    // Returns at the posedge one clock after a tick-consuming edge, fixing bit-to-tick phase.
    task automatic align();
        @(posedge clk);
        while (tick !== 1'b1) @(posedge clk);
        @(posedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input int nbits,
                              input logic stop_v, input int stop_clks);
        logic [7:0] dv;
        dv = d;
        #1 drive(sel, 1'b0);
        repeat (64) @(posedge clk);
        for (int k = 0; k < nbits; k++) begin
            #1 drive(sel, dv[k]);
            repeat (64) @(posedge clk);
        end
        #1 drive(sel, stop_v);
        repeat (stop_clks) @(posedge clk);
    endtask

    task automatic idle(input int sel, input int clks);
        #1 drive(sel, 1'b1);
        repeat (clks) @(posedge clk);
    endtask

    task automatic expect_frame(input int sel, input logic [7:0] d, input logic e);
        if (sel == 0) exp8_q.push_back({23'd0, e, d});
        else          exp7_q.push_back({23'd0, e, d});
    endtask

    // scoreboard: compare every observed strobe against the expected queue, then clear
    task automatic drain(input int sel, input string tag, input int exp_tk);
        logic [31:0] o_q[$], e_q[$];
        int          t_q[$], l_q[$];
        if (sel == 0) begin
            o_q = obs8_q; e_q = exp8_q; t_q = tk8_q; l_q = lat8_q;
            obs8_q.delete(); exp8_q.delete(); tk8_q.delete(); lat8_q.delete();
        end else begin
            o_q = obs7_q; e_q = exp7_q; t_q = tk7_q; l_q = lat7_q;
            obs7_q.delete(); exp7_q.delete(); tk7_q.delete(); lat7_q.delete();
        end
        check({tag, "_count"}, o_q.size(), e_q.size());
        for (int i = 0; i < o_q.size() && i < e_q.size(); i++) begin
            check({tag, "_data"}, o_q[i] & 32'hFF, e_q[i] & 32'hFF);
            check({tag, "_ferr"}, 32'(o_q[i][8]), 32'(e_q[i][8]));
            if (exp_tk != 0) begin
                check({tag, "_stop_ticks"}, t_q[i], exp_tk);
                check({tag, "_latency"}, l_q[i], 1);
            end
        end
    endtask

    initial begin
        // reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_ferr", 32'(err8), 0);
        check("rst_state", 32'(st8), 32'(ST_IDLE));
        check("rst_data7", 32'(data7), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0, 20);

        // good frame with timing of the strobe
        align();
        expect_frame(0, 8'hA5, 1'b0);
        send_frame(0, 8'hA5, 8, 1'b1, 64);
        idle(0, 100);
        drain(0, "a5", 16);

        // low stop bit, then a good frame clears the error
        align();
        expect_frame(0, 8'h3C, 1'b1);
        send_frame(0, 8'h3C, 8, 1'b0, 64);
        idle(0, 200);
        drain(0, "bad_stop", 0);
        align();
        expect_frame(0, 8'h81, 1'b0);
        send_frame(0, 8'h81, 8, 1'b1, 64);
        idle(0, 100);
        drain(0, "after_err", 0);

        // 3-tick low glitch
        align();
        #1 drive(0, 1'b0);
        repeat (12) @(posedge clk);
        idle(0, 100);
        drain(0, "glitch", 0);
        @(negedge clk);
        check("glitch_state", 32'(st8), 32'(ST_IDLE));
        align();
        expect_frame(0, 8'h5A, 1'b0);
        send_frame(0, 8'h5A, 8, 1'b1, 64);
        idle(0, 100);
        drain(0, "post_glitch", 0);

        // back-to-back frames, no idle gap
        align();
        expect_frame(0, 8'h00, 1'b0);
        expect_frame(0, 8'hFF, 1'b0);
        expect_frame(0, 8'h55, 1'b0);
        send_frame(0, 8'h00, 8, 1'b1, 64);
        send_frame(0, 8'hFF, 8, 1'b1, 64);
        send_frame(0, 8'h55, 8, 1'b1, 64);
        idle(0, 100);
        drain(0, "b2b", 0);

        // reset during data bit 4 of 0xC3
        align();
        fork
            send_frame(0, 8'hC3, 8, 1'b1, 64);
            begin
                repeat (340) @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                check("mid_rst_data", 32'(data8), 0);
                check("mid_rst_done", 32'(done8), 0);
                check("mid_rst_ferr", 32'(err8), 0);
                check("mid_rst_state", 32'(st8), 32'(ST_IDLE));
            end
        join
        idle(0, 20);
        #1 rst_n = 1'b1;
        idle(0, 20);
        drain(0, "rst_c3", 0);
        align();
        expect_frame(0, 8'h96, 1'b0);
        send_frame(0, 8'h96, 8, 1'b1, 64);
        idle(0, 100);
        drain(0, "after_rst", 0);

        // 7 data bits, 2 stop bits
        align();
        expect_frame(1, 8'h2B, 1'b0);
        send_frame(1, 8'h2B, 7, 1'b1, 128);
        idle(1, 100);
        drain(1, "db7", 32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
